// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for the multi-cycle RISC-V datapath (R, I-ALU, LW, SW, BEQ).
// Memory waits are guarded by a watchdog; illegal opcodes and timeouts park the FSM in TRAP.
module riscv_multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int WAIT_W  = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_cond,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic [3:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] retired,
  output logic             trap
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [3:0]       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [6:0]       opcode;
  logic             in_wait_state;

  assign opcode        = instruction[6:0];
  assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Timeout is checked before the wait state's own transition; completion overrides it below.
  always_comb begin
    state_d = state_q;
    if (in_wait_state && !mem_ready && (wait_q == WAIT_LAST)) state_d = S_TRAP;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I:            state_d = S_WB_ALU;
      S_MEM_ADDR:                    state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_BRANCH:  state_d = S_FETCH;
      S_TRAP:                        state_d = S_TRAP;
      default:                       state_d = S_TRAP;
    endcase
  end

  // Counter is zero whenever a wait state is entered, since every transition clears it.
  always_comb begin
    wait_d = '0;
    if (in_wait_state && !mem_ready && (state_d == state_q)) wait_d = wait_q + 1'b1;
    retired_d = retire ? retired_q + 1'b1 : retired_q;
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_cond    = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    aluop      = 2'b00;
    retire     = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b10;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluop     = 2'b10;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD:   mem_read = 1'b1;
      S_MEM_WR: begin
        mem_write = 1'b1;
        retire    = mem_ready;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = 2'b01;
        pc_cond   = zero;
        retire    = 1'b1;
      end
      S_TRAP:     trap = 1'b1;
      default: ;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: inputs change and outputs are sampled 1ns after each rising edge.
module tb_riscv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_cond, ir_write, mem_read, mem_write, reg_write, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, aluop;
  logic [3:0]  state;
  logic        retire;
  logic [31:0] retired;
  logic        trap;

  int total = 0;
  int bad   = 0;

  riscv_multicycle_ctrl #(.TIMEOUT(15), .WAIT_W(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_cond(pc_cond), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .state(state),
    .retire(retire), .retired(retired), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int rd_cycles;
    reset = 1'b1; instruction = 32'h0; zero = 1'b0; mem_ready = 1'b0;

    // T1 reset
    do_reset();
    chk("t1_state", 32'(state), 0);
    chk("t1_mem_read", 32'(mem_read), 1);
    chk("t1_retired", retired, 0);
    chk("t1_trap", 32'(trap), 0);
    chk("t1_pc_write_idle", 32'(pc_write), 0);
    chk("t1_alu_src_b", 32'(alu_src_b), 1);

    // T2 add x5,x6,x7
    instruction = 32'h007302B3; mem_ready = 1'b1; #1;
    chk("t2_pc_write", 32'(pc_write), 1);
    chk("t2_ir_write", 32'(ir_write), 1);
    step(); chk("t2_decode", 32'(state), 1);
    chk("t2_dec_srcb", 32'(alu_src_b), 2);
    step(); chk("t2_exec_r", 32'(state), 2);
    chk("t2_aluop", 32'(aluop), 2);
    chk("t2_srca", 32'(alu_src_a), 1);
    step(); chk("t2_wb_alu", 32'(state), 7);
    chk("t2_reg_write", 32'(reg_write), 1);
    chk("t2_retire", 32'(retire), 1);
    chk("t2_mem_to_reg", 32'(mem_to_reg), 0);
    step(); chk("t2_fetch", 32'(state), 0);
    chk("t2_retired", retired, 1);

    // T3 lw with 3 stall cycles in MEM_RD: 8 cycles total
    instruction = 32'h0002A303;
    step(); chk("t3_decode", 32'(state), 1);
    step(); chk("t3_mem_addr", 32'(state), 4);
    mem_ready = 1'b0;
    step(); chk("t3_mem_rd", 32'(state), 5);
    rd_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      if (state == 4'd5 && mem_read) rd_cycles++;
      if (i < 3) step();
    end
    chk("t3_rd_cycles", 32'(rd_cycles), 4);
    step(); chk("t3_wb_mem", 32'(state), 8);
    chk("t3_mem_to_reg", 32'(mem_to_reg), 1);
    chk("t3_reg_write", 32'(reg_write), 1);
    step(); chk("t3_fetch", 32'(state), 0);
    chk("t3_retired", retired, 2);

    // T4 beq taken, then not taken
    instruction = 32'h00000063; zero = 1'b1;
    step(); step(); chk("t4_branch", 32'(state), 9);
    chk("t4_aluop", 32'(aluop), 1);
    chk("t4_pc_cond1", 32'(pc_cond), 1);
    chk("t4_retire", 32'(retire), 1);
    step(); chk("t4_retired1", retired, 3);
    zero = 1'b0;
    step(); step(); chk("t4_branch2", 32'(state), 9);
    chk("t4_pc_cond0", 32'(pc_cond), 0);
    step(); chk("t4_retired2", retired, 4);

    // T6 reset asserted mid store
    instruction = 32'h0062A023;
    step(); step(); mem_ready = 1'b0;
    step(); chk("t6_mem_wr", 32'(state), 6);
    chk("t6_mem_write", 32'(mem_write), 1);
    chk("t6_no_retire", 32'(retire), 0);
    reset = 1'b1; #1;
    chk("t6_write_drop", 32'(mem_write), 0);
    chk("t6_state", 32'(state), 0);
    step(); reset = 1'b0;
    chk("t6_retired", retired, 0);
    mem_ready = 1'b1; #1;
    chk("t6_resume_pc", 32'(pc_write), 1);
    step(); chk("t6_resume_dec", 32'(state), 1);

    // T5 illegal opcode traps and stays trapped
    do_reset();
    instruction = 32'h0000007F; mem_ready = 1'b1;
    step(); step(); chk("t5_trap_state", 32'(state), 10);
    chk("t5_trap", 32'(trap), 1);
    step(); step();
    chk("t5_trap_held", 32'(trap), 1);
    chk("t5_mem_read_off", 32'(mem_read), 0);

    // T5 fetch watchdog: 15 stalled cycles trap
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("t5_wd_before", 32'(state), 0);
    step(); chk("t5_wd_trap", 32'(state), 10);

    // completion on the final cycle beats the timeout
    do_reset();
    instruction = 32'h007302B3; mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step();
    mem_ready = 1'b1;
    step(); chk("t5_ready_wins", 32'(state), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
